// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the MCB access arbiter.
// arb_state codes double as the FSM state encoding so the state register
// can drive arb_state directly.
package mem_arb_pkg;

  localparam logic [1:0] ARB_RD   = 2'b00;
  localparam logic [1:0] ARB_WR   = 2'b01;
  localparam logic [1:0] ARB_IDLE = 2'b10;
  localparam logic [1:0] ARB_REL  = 2'b11;

  typedef enum logic [1:0] {
    ST_GNT_RD = ARB_RD,
    ST_GNT_WR = ARB_WR,
    ST_IDLE   = ARB_IDLE,
    ST_REL    = ARB_REL
  } arb_st_e;

  // Saturating increment of the consecutive-read counter.
  function automatic logic [2:0] rd_cnt_inc(input logic [2:0] cnt, input logic [2:0] max);
    return (cnt >= max) ? max : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// arb_wdt: loadable down-counter with an expiry pulse.
// expired is high while en is set and the count has reached zero.
module arb_wdt #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Count down while enabled; reload on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port MCB arbiter between the line-read (display) and
// line-write (capture) controllers. Reads win unless MAX_RD_RUN consecutive
// reads have been granted while a write is pending.
// Optional watchdog: define MEM_ARB_WDT_EN to force-release stuck grants.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_RD_RUN = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned TO_W       = 13
) (
  input  logic       memclk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       rd_donep,
  input  logic       wr_donep,
  output logic       rd_memcon_en,
  output logic       wr_memcon_en,
  output logic [1:0] arb_state,
  output logic       timeout_err,
  output logic [2:0] rd_run_cnt
);

  localparam logic [2:0] RUN_MAX = 3'(MAX_RD_RUN);

  if (TIMEOUT < 2 || TIMEOUT > (1 << TO_W)) begin : g_bad_timeout
    $error("mem_arb: TIMEOUT must be in 2..2**TO_W");
  end

  arb_st_e    state, state_nxt;
  logic       owner_wr, owner_wr_nxt;
  logic [2:0] cnt_nxt;
  logic       rd_en_nxt, wr_en_nxt;
  logic       wdt_exp;

  // State, owner, fairness counter and registered grant enables.
  always_ff @(posedge memclk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_wr     <= 1'b0;
      rd_run_cnt   <= '0;
      rd_memcon_en <= 1'b0;
      wr_memcon_en <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner_wr     <= owner_wr_nxt;
      rd_run_cnt   <= cnt_nxt;
      rd_memcon_en <= rd_en_nxt;
      wr_memcon_en <= wr_en_nxt;
    end
  end

  // Next-state: grant selection in IDLE, donep handshake in grant/release.
  always_comb begin
    state_nxt    = state;
    owner_wr_nxt = owner_wr;
    cnt_nxt      = rd_run_cnt;
    unique case (state)
      ST_IDLE: begin
        if (rd_req && !rd_donep && !(wr_req && (rd_run_cnt == RUN_MAX))) begin
          state_nxt    = ST_GNT_RD;
          owner_wr_nxt = 1'b0;
          cnt_nxt      = rd_cnt_inc(rd_run_cnt, RUN_MAX);
        end else if (wr_req && !wr_donep) begin
          state_nxt    = ST_GNT_WR;
          owner_wr_nxt = 1'b1;
          cnt_nxt      = '0;
        end else if (!wr_req) begin
          cnt_nxt = '0;
        end
      end
      ST_GNT_RD: if (rd_donep) state_nxt = ST_REL;
      ST_GNT_WR: if (wr_donep) state_nxt = ST_REL;
      ST_REL:    if (!(owner_wr ? wr_donep : rd_donep)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (wdt_exp) state_nxt = ST_IDLE;
  end

  // Output decode from the next state so the enables leave a flop.
  always_comb begin
    rd_en_nxt = (state_nxt == ST_GNT_RD);
    wr_en_nxt = (state_nxt == ST_GNT_WR);
  end

  assign arb_state = state;

`ifdef MEM_ARB_WDT_EN
  logic grant_entry;
  assign grant_entry = (state == ST_IDLE) && (state_nxt != ST_IDLE);

  // Loaded with TIMEOUT-2 so expiry lands on the edge that would make the
  // up-count equal TIMEOUT-1, i.e. the grant ends after TIMEOUT-1 cycles.
  arb_wdt #(.W(TO_W)) u_wdt (
    .clk      (memclk),
    .rst      (rst),
    .load     (grant_entry),
    .load_val (TO_W'(TIMEOUT - 2)),
    .en       (state != ST_IDLE),
    .expired  (wdt_exp)
  );

  // Sticky watchdog error, cleared only by reset.
  always_ff @(posedge memclk) begin
    if (rst)          timeout_err <= 1'b0;
    else if (wdt_exp) timeout_err <= 1'b1;
  end
`else
  assign wdt_exp     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb (watchdog section needs MEM_ARB_WDT_EN).
module tb_mem_arb;

  logic       memclk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0, wr_req = 1'b0, rd_donep = 1'b0, wr_donep = 1'b0;
  logic       rd_memcon_en, wr_memcon_en, timeout_err;
  logic [1:0] arb_state;
  logic [2:0] rd_run_cnt;

  int errors = 0;
  int checks = 0;

  always #5 memclk = ~memclk;

  mem_arb #(.MAX_RD_RUN(4), .TIMEOUT(16), .TO_W(13)) dut (
    .memclk       (memclk),
    .rst          (rst),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .rd_donep     (rd_donep),
    .wr_donep     (wr_donep),
    .rd_memcon_en (rd_memcon_en),
    .wr_memcon_en (wr_memcon_en),
    .arb_state    (arb_state),
    .timeout_err  (timeout_err),
    .rd_run_cnt   (rd_run_cnt)
  );

  task automatic tick();
    @(posedge memclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic wr, input logic [1:0] st);
    chk({tag, ".rd_en"}, {7'd0, rd_memcon_en}, {7'd0, rd});
    chk({tag, ".wr_en"}, {7'd0, wr_memcon_en}, {7'd0, wr});
    chk({tag, ".state"}, {6'd0, arb_state}, {6'd0, st});
  endtask

  logic [9:0] exp_wr;
  logic [2:0] model_cnt;

  initial begin
    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst", 1'b0, 1'b0, 2'b10);
      chk("rst.err", {7'd0, timeout_err}, 8'h0);
      chk("rst.cnt", {5'd0, rd_run_cnt}, 8'h0);
    end
    rst = 1'b0;
    tick();
    chk_out("idle", 1'b0, 1'b0, 2'b10);

    // 2: single read transaction; request drop mid-grant does not abort
    rd_req = 1'b1;
    tick();
    chk_out("rd.gnt", 1'b1, 1'b0, 2'b00);
    chk("rd.cnt", {5'd0, rd_run_cnt}, 8'd1);
    rd_req = 1'b0;
    tick();
    chk_out("rd.hold", 1'b1, 1'b0, 2'b00);
    rd_donep = 1'b1;
    tick();
    chk_out("rd.rel", 1'b0, 1'b0, 2'b11);
    tick();
    chk_out("rd.rel2", 1'b0, 1'b0, 2'b11);
    rd_donep = 1'b0;
    tick();
    chk_out("rd.idle", 1'b0, 1'b0, 2'b10);
    tick();
    chk("rd.cntclr", {5'd0, rd_run_cnt}, 8'd0);

    // 3: both requesting -> R,R,R,R,W,R,R,R,R,W
    exp_wr = 10'b10000_10000;
    model_cnt = 3'd0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      model_cnt = exp_wr[i] ? 3'd0 : ((model_cnt == 3'd4) ? 3'd4 : model_cnt + 3'd1);
      chk_out($sformatf("mix%0d", i), !exp_wr[i], exp_wr[i], {1'b0, exp_wr[i]});
      chk($sformatf("mix%0d.cnt", i), {5'd0, rd_run_cnt}, {5'd0, model_cnt});
      if (exp_wr[i]) wr_donep = 1'b1; else rd_donep = 1'b1;
      tick();
      chk($sformatf("mix%0d.onehot", i), {7'd0, rd_memcon_en & wr_memcon_en}, 8'h0);
      chk($sformatf("mix%0d.rel", i), {6'd0, arb_state}, 8'h3);
      rd_donep = 1'b0;
      wr_donep = 1'b0;
      tick();
      chk($sformatf("mix%0d.idle", i), {6'd0, arb_state}, 8'h2);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();

    // 4: write blocked while its donep is still high
    wr_req = 1'b1;
    wr_donep = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("wrblk", 1'b0, 1'b0, 2'b10);
    end
    wr_donep = 1'b0;
    tick();
    chk_out("wr.gnt", 1'b0, 1'b1, 2'b01);
    chk("wr.cnt", {5'd0, rd_run_cnt}, 8'd0);
    rd_donep = 1'b1;
    tick();
    chk_out("wr.nonowner", 1'b0, 1'b1, 2'b01);
    rd_donep = 1'b0;

    // 6: reset during a write grant, then during a read grant
    rst = 1'b1;
    tick();
    chk_out("rstwr", 1'b0, 1'b0, 2'b10);
    chk("rstwr.cnt", {5'd0, rd_run_cnt}, 8'd0);
    rst = 1'b0;
    wr_req = 1'b0;
    tick();
    rd_req = 1'b1;
    tick();
    chk_out("rd2.gnt", 1'b1, 1'b0, 2'b00);
    chk("rd2.cnt", {5'd0, rd_run_cnt}, 8'd1);
    rst = 1'b1;
    rd_req = 1'b0;
    tick();
    chk_out("rstrd", 1'b0, 1'b0, 2'b10);
    chk("rstrd.cnt", {5'd0, rd_run_cnt}, 8'd0);
    rst = 1'b0;
    tick();

`ifdef MEM_ARB_WDT_EN
    // 5: stuck read grant is released by the watchdog after 15 cycles
    rd_req = 1'b1;
    tick();
    chk_out("wdt.gnt", 1'b1, 1'b0, 2'b00);
    rd_req = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk($sformatf("wdt.c%0d", c), {7'd0, rd_memcon_en}, 8'h1);
    end
    tick();
    chk_out("wdt.exp", 1'b0, 1'b0, 2'b10);
    chk("wdt.err", {7'd0, timeout_err}, 8'h1);
    repeat (3) tick();
    chk("wdt.sticky", {7'd0, timeout_err}, 8'h1);
    chk_out("wdt.idle", 1'b0, 1'b0, 2'b10);
`else
    // Without the watchdog a grant stays open indefinitely.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (20) tick();
    chk_out("nowdt.hold", 1'b1, 1'b0, 2'b00);
    chk("nowdt.err", {7'd0, timeout_err}, 8'h0);
    rd_donep = 1'b1;
    tick();
    chk_out("nowdt.rel", 1'b0, 1'b0, 2'b11);
    rd_donep = 1'b0;
    tick();
    chk_out("nowdt.idle", 1'b0, 1'b0, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
